// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared constants for the control sequencer.
// Opcode values, control-word bit indices and FSM state encoding.
package ctrl_seq_pkg;

  localparam int unsigned CW_W = 16;

  // Control-word bit indices
  localparam logic [3:0] HLT     = 4'd0;
  localparam logic [3:0] MAR_IN  = 4'd1;
  localparam logic [3:0] MEM_RD  = 4'd2;
  localparam logic [3:0] MEM_WR  = 4'd3;
  localparam logic [3:0] IR_IN   = 4'd4;
  localparam logic [3:0] IR_OUT  = 4'd5;
  localparam logic [3:0] PC_OUT  = 4'd6;
  localparam logic [3:0] PC_INC  = 4'd7;
  localparam logic [3:0] PC_LOAD = 4'd8;
  localparam logic [3:0] A_IN    = 4'd9;
  localparam logic [3:0] A_OUT   = 4'd10;
  localparam logic [3:0] B_IN    = 4'd11;
  localparam logic [3:0] ALU_OUT = 4'd12;
  localparam logic [3:0] ALU_SUB = 4'd13;
  localparam logic [3:0] OUT_IN  = 4'd14;
  localparam logic [3:0] FLAG_IN = 4'd15;

  // Opcodes (upper nibble of IR)
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LDA    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_STA    = 4'd4;
  localparam logic [3:0] OP_LDI    = 4'd5;
  localparam logic [3:0] OP_JMP    = 4'd6;
  localparam logic [3:0] OP_JC     = 4'd7;
  localparam logic [3:0] OP_JZ     = 4'd8;
  localparam logic [3:0] OP_ILL_LO = 4'd9;
  localparam logic [3:0] OP_ILL_HI = 4'd13;
  localparam logic [3:0] OP_OUT    = 4'd14;
  localparam logic [3:0] OP_HLT    = 4'd15;

  // Highest micro-step any opcode uses
  localparam logic [2:0] STEP_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // One-hot control word for a single bit index
  function automatic logic [CW_W-1:0] cw_bit(input logic [3:0] idx);
    cw_bit = {{(CW_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Bits that must not take effect while a memory access is stalled
  localparam logic [CW_W-1:0] WAIT_MASK = cw_bit(IR_IN) | cw_bit(PC_INC) |
                                          cw_bit(A_IN)  | cw_bit(B_IN)   |
                                          cw_bit(FLAG_IN);

endpackage

// File: rtl/ctrl_seq_decode_rom.sv
// ctrl_seq_decode_rom: combinational (opcode, step, flags) -> control word
// and last-step indication. Conditional jumps exist only when
// CTRL_SEQ_COND_JUMP_EN is defined; otherwise JC/JZ decode as illegal.
module ctrl_seq_decode_rom
  import ctrl_seq_pkg::*;
(
  input  logic [3:0]      opcode,
  input  logic [2:0]      step,
  input  logic [1:0]      flags,
  output logic [CW_W-1:0] word,
  output logic            last,
  output logic            illegal_op
);

  logic [2:0] last_step;

`ifndef CTRL_SEQ_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = ^flags;
`endif

  // Classify opcodes that have no defined execute sequence
  always_comb begin
    illegal_op = 1'b0;
    if (opcode >= OP_ILL_LO && opcode <= OP_ILL_HI) illegal_op = 1'b1;
`ifndef CTRL_SEQ_COND_JUMP_EN
    if (opcode == OP_JC || opcode == OP_JZ) illegal_op = 1'b1;
`endif
  end

  // Fetch for T0/T1, opcode-specific execute from T2
  always_comb begin
    word      = '0;
    last_step = 3'd2;
    case (opcode)
      OP_LDA: begin
        last_step = 3'd3;
        if (step == 3'd2)      word = cw_bit(IR_OUT) | cw_bit(MAR_IN);
        else if (step == 3'd3) word = cw_bit(MEM_RD) | cw_bit(A_IN);
      end
      OP_ADD, OP_SUB: begin
        last_step = 3'd4;
        if (step == 3'd2)      word = cw_bit(IR_OUT) | cw_bit(MAR_IN);
        else if (step == 3'd3) word = cw_bit(MEM_RD) | cw_bit(B_IN);
        else if (step == 3'd4) begin
          word = cw_bit(ALU_OUT) | cw_bit(A_IN) | cw_bit(FLAG_IN);
          if (opcode == OP_SUB) word = word | cw_bit(ALU_SUB);
        end
      end
      OP_STA: begin
        last_step = 3'd3;
        if (step == 3'd2)      word = cw_bit(IR_OUT) | cw_bit(MAR_IN);
        else if (step == 3'd3) word = cw_bit(A_OUT) | cw_bit(MEM_WR);
      end
      OP_LDI: if (step == 3'd2) word = cw_bit(IR_OUT) | cw_bit(A_IN);
      OP_JMP: if (step == 3'd2) word = cw_bit(IR_OUT) | cw_bit(PC_LOAD);
`ifdef CTRL_SEQ_COND_JUMP_EN
      OP_JC:  if (step == 3'd2 && flags[1]) word = cw_bit(IR_OUT) | cw_bit(PC_LOAD);
      OP_JZ:  if (step == 3'd2 && flags[0]) word = cw_bit(IR_OUT) | cw_bit(PC_LOAD);
`endif
      OP_OUT: if (step == 3'd2) word = cw_bit(A_OUT) | cw_bit(OUT_IN);
      OP_HLT: if (step == 3'd2) word = cw_bit(HLT);
      default: word = '0;
    endcase
    if (step == 3'd0)      word = cw_bit(PC_OUT) | cw_bit(MAR_IN);
    else if (step == 3'd1) word = cw_bit(MEM_RD) | cw_bit(IR_IN) | cw_bit(PC_INC);
    last = (step >= last_step);
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: micro-coded control unit (INIT/RUN/HALT FSM, memory
// wait masking, sticky illegal flag, latched ALU flags).
// Optional: CTRL_SEQ_COND_JUMP_EN enables JC/JZ and the flags register.
module control_sequencer
  import ctrl_seq_pkg::*;
(
  input  logic            ctrl_seq_clk,
  input  logic            ctrl_seq_rst_n,
  input  logic [2:0]      ctrl_seq_step_in,
  input  logic [3:0]      ctrl_seq_ir_opcode,
  input  logic [1:0]      ctrl_seq_alu_flags,
  input  logic            ctrl_seq_mem_ready,
  output logic [CW_W-1:0] ctrl_seq_word,
  output logic            ctrl_seq_step_rst,
  output logic            ctrl_seq_step_hold,
  output logic            ctrl_seq_halted,
  output logic            ctrl_seq_illegal
);

  seq_state_t      state, state_nxt;
  logic [1:0]      flags_q;
  logic [CW_W-1:0] rom_word;
  logic            rom_last;
  logic            rom_illegal;
  logic            mem_wait;
  logic            illegal_q;

  ctrl_seq_decode_rom u_rom (
    .opcode     (ctrl_seq_ir_opcode),
    .step       (ctrl_seq_step_in),
    .flags      (flags_q),
    .word       (rom_word),
    .last       (rom_last),
    .illegal_op (rom_illegal)
  );

  // State register
  always_ff @(posedge ctrl_seq_clk or negedge ctrl_seq_rst_n) begin
    if (!ctrl_seq_rst_n) state <= ST_INIT;
    else                 state <= state_nxt;
  end

  // Next state and all control outputs; a stalled access keeps address and
  // read/write strobes but suppresses register loads and the step clear
  always_comb begin
    state_nxt          = state;
    ctrl_seq_word      = '0;
    ctrl_seq_step_rst  = 1'b0;
    ctrl_seq_step_hold = 1'b0;
    ctrl_seq_halted    = 1'b0;
    mem_wait           = 1'b0;
    case (state)
      ST_INIT: begin
        ctrl_seq_step_rst = 1'b1;
        state_nxt         = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl_seq_step_in > STEP_MAX) begin
          ctrl_seq_step_rst = 1'b1;
        end else begin
          mem_wait = (rom_word[MEM_RD] | rom_word[MEM_WR]) & ~ctrl_seq_mem_ready;
          if (mem_wait) begin
            ctrl_seq_word      = rom_word & ~WAIT_MASK;
            ctrl_seq_step_hold = 1'b1;
          end else begin
            ctrl_seq_word     = rom_word;
            ctrl_seq_step_rst = rom_last;
          end
          if (rom_word[HLT]) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        ctrl_seq_word      = cw_bit(HLT);
        ctrl_seq_step_hold = 1'b1;
        ctrl_seq_halted    = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

`ifdef CTRL_SEQ_COND_JUMP_EN
  // Latch ALU flags when the issued word carries FLAG_IN
  always_ff @(posedge ctrl_seq_clk or negedge ctrl_seq_rst_n) begin
    if (!ctrl_seq_rst_n)                            flags_q <= '0;
    else if (state == ST_RUN && ctrl_seq_word[FLAG_IN]) flags_q <= ctrl_seq_alu_flags;
  end
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^ctrl_seq_alu_flags;
  assign flags_q          = '0;
`endif

  // Sticky illegal-opcode flag, sampled at the first execute step
  always_ff @(posedge ctrl_seq_clk or negedge ctrl_seq_rst_n) begin
    if (!ctrl_seq_rst_n) illegal_q <= 1'b0;
    else if (state == ST_RUN && ctrl_seq_step_in == 3'd2 && rom_illegal) illegal_q <= 1'b1;
  end

  assign ctrl_seq_illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vectors with hand-computed expectations.
// Expectations for JC follow the CTRL_SEQ_COND_JUMP_EN build setting.
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  step;
  logic [3:0]  op;
  logic [1:0]  flags;
  logic        ready;
  logic [15:0] word;
  logic        srst, hold, halted, illegal;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  control_sequencer dut (
    .ctrl_seq_clk       (clk),
    .ctrl_seq_rst_n     (rst_n),
    .ctrl_seq_step_in   (step),
    .ctrl_seq_ir_opcode (op),
    .ctrl_seq_alu_flags (flags),
    .ctrl_seq_mem_ready (ready),
    .ctrl_seq_word      (word),
    .ctrl_seq_step_rst  (srst),
    .ctrl_seq_step_hold (hold),
    .ctrl_seq_halted    (halted),
    .ctrl_seq_illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] b(input logic [3:0] idx);
    logic [15:0] one;
    one = 16'h0001;
    return one << idx;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [2:0] s, input logic [3:0] o, input logic r);
    step  = s;
    op    = o;
    ready = r;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_word"}, word, 16'h0000);
    chk({tag, "_srst"}, {15'd0, srst}, 16'd1);
    chk({tag, "_hold"}, {15'd0, hold}, 16'd0);
    chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    chk({tag, "_illegal"}, {15'd0, illegal}, 16'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; step = '0; op = '0; flags = '0; ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst");

    // Release between edges: INIT lasts exactly one cycle
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("init_srst", {15'd0, srst}, 16'd1);
    chk("init_word", word, 16'h0000);
    cyc();
    apply(3'd0, OP_NOP, 1'b1);
    chk("fetch_t0", word, b(PC_OUT) | b(MAR_IN));
    chk("fetch_t0_srst", {15'd0, srst}, 16'd0);
    cyc();

    // ADD full sequence, flags {carry=1, zero=0}
    apply(3'd0, OP_ADD, 1'b1); chk("add_t0", word, b(PC_OUT) | b(MAR_IN)); cyc();
    apply(3'd1, OP_ADD, 1'b1); chk("add_t1", word, b(MEM_RD) | b(IR_IN) | b(PC_INC));
    chk("add_t1_hold", {15'd0, hold}, 16'd0); cyc();
    apply(3'd2, OP_ADD, 1'b1); chk("add_t2", word, b(IR_OUT) | b(MAR_IN));
    chk("add_t2_srst", {15'd0, srst}, 16'd0); cyc();
    apply(3'd3, OP_ADD, 1'b1); chk("add_t3", word, b(MEM_RD) | b(B_IN));
    chk("add_t3_srst", {15'd0, srst}, 16'd0); cyc();
    flags = 2'b10;
    apply(3'd4, OP_ADD, 1'b1); chk("add_t4", word, b(ALU_OUT) | b(A_IN) | b(FLAG_IN));
    chk("add_t4_srst", {15'd0, srst}, 16'd1); cyc();
    flags = 2'b01;   // live flags differ from latched ones

    apply(3'd2, OP_JC, 1'b1);
`ifdef CTRL_SEQ_COND_JUMP_EN
    chk("jc_t2", word, b(IR_OUT) | b(PC_LOAD));
`else
    chk("jc_t2", word, 16'h0000);
`endif
    chk("jc_t2_srst", {15'd0, srst}, 16'd1); cyc();
`ifdef CTRL_SEQ_COND_JUMP_EN
    chk("jc_illegal", {15'd0, illegal}, 16'd0);
`else
    chk("jc_illegal", {15'd0, illegal}, 16'd1);
`endif
    apply(3'd2, OP_JZ, 1'b1); chk("jz_t2", word, 16'h0000);
    chk("jz_t2_srst", {15'd0, srst}, 16'd1); cyc();

    rst_n = 1'b0; #1;
    chk_reset_vals("rst2");
    release_reset();

    // Fetch stalled for three cycles
    for (int i = 0; i < 3; i++) begin
      apply(3'd1, OP_NOP, 1'b0);
      chk("wait_word", word, b(MEM_RD));
      chk("wait_hold", {15'd0, hold}, 16'd1);
      chk("wait_srst", {15'd0, srst}, 16'd0);
      cyc();
    end
    apply(3'd1, OP_NOP, 1'b1);
    chk("wait_done_word", word, b(MEM_RD) | b(IR_IN) | b(PC_INC));
    chk("wait_done_hold", {15'd0, hold}, 16'd0); cyc();

    // STA with stalled write at its last step
    apply(3'd2, OP_STA, 1'b1); chk("sta_t2", word, b(IR_OUT) | b(MAR_IN)); cyc();
    apply(3'd3, OP_STA, 1'b0); chk("sta_t3_wait", word, b(A_OUT) | b(MEM_WR));
    chk("sta_t3_wait_hold", {15'd0, hold}, 16'd1);
    chk("sta_t3_wait_srst", {15'd0, srst}, 16'd0); cyc();
    apply(3'd3, OP_STA, 1'b1); chk("sta_t3", word, b(A_OUT) | b(MEM_WR));
    chk("sta_t3_srst", {15'd0, srst}, 16'd1); cyc();

    apply(3'd3, OP_LDA, 1'b1); chk("lda_t3", word, b(MEM_RD) | b(A_IN));
    chk("lda_t3_srst", {15'd0, srst}, 16'd1); cyc();
    apply(3'd2, OP_LDI, 1'b1); chk("ldi_t2", word, b(IR_OUT) | b(A_IN));
    chk("ldi_t2_srst", {15'd0, srst}, 16'd1); cyc();
    apply(3'd2, OP_JMP, 1'b1); chk("jmp_t2", word, b(IR_OUT) | b(PC_LOAD)); cyc();
    apply(3'd2, OP_OUT, 1'b1); chk("out_t2", word, b(A_OUT) | b(OUT_IN)); cyc();
    flags = 2'b00;
    apply(3'd4, OP_SUB, 1'b1);
    chk("sub_t4", word, b(ALU_OUT) | b(A_IN) | b(FLAG_IN) | b(ALU_SUB));
    chk("sub_t4_srst", {15'd0, srst}, 16'd1); cyc();
    apply(3'd2, OP_NOP, 1'b1); chk("nop_t2", word, 16'h0000);
    chk("nop_t2_srst", {15'd0, srst}, 16'd1); cyc();
    apply(3'd5, OP_ADD, 1'b1); chk("step5_word", word, 16'h0000);
    chk("step5_srst", {15'd0, srst}, 16'd1);
    apply(3'd7, OP_LDA, 1'b0); chk("step7_word", word, 16'h0000);
    chk("step7_hold", {15'd0, hold}, 16'd0); cyc();

    // Illegal opcode, sticky across later instructions
    chk("pre_illegal", {15'd0, illegal}, 16'd0);
    apply(3'd2, 4'd10, 1'b1); chk("ill_word", word, 16'h0000);
    chk("ill_srst", {15'd0, srst}, 16'd1); cyc();
    chk("ill_set", {15'd0, illegal}, 16'd1);
    apply(3'd0, OP_LDA, 1'b1); cyc();
    apply(3'd2, OP_LDI, 1'b1); cyc();
    chk("ill_sticky", {15'd0, illegal}, 16'd1);

    // Reset in the middle of a stalled access
    apply(3'd1, OP_NOP, 1'b0); chk("midwait_hold", {15'd0, hold}, 16'd1);
    rst_n = 1'b0; #1;
    chk_reset_vals("rst_midwait");
    release_reset();

    // HLT
    apply(3'd2, OP_HLT, 1'b1); chk("hlt_t2", word, b(HLT));
    chk("hlt_t2_halted", {15'd0, halted}, 16'd0); cyc();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_hold", {15'd0, hold}, 16'd1);
    chk("halt_word", word, b(HLT));
    chk("halt_srst", {15'd0, srst}, 16'd0);
    apply(3'd0, OP_LDA, 1'b1); cyc();
    chk("halt_stays_word", word, b(HLT));
    chk("halt_stays", {15'd0, halted}, 16'd1);
    rst_n = 1'b0; #1;
    chk_reset_vals("rst_midhalt");
    release_reset();
    apply(3'd0, OP_NOP, 1'b1);
    chk("post_halt_fetch", word, b(PC_OUT) | b(MAR_IN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clocking and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-002 ctrl_seq_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 ctrl_seq_rst_n  in  1  asynchronous active-low reset.
REQ-004 ctrl_seq_step_in  in  3  micro-step number from the instruction step counter (T0..T7).
REQ-005 ctrl_seq_ir_opcode  in  4  upper nibble of the instruction register.
REQ-006 ctrl_seq_alu_flags  in  2  {carry, zero} from the ALU.
REQ-007 ctrl_seq_mem_ready  in  1  memory access completes this cycle.
REQ-008 ctrl_seq_word  out  16  control word (bit map in package).
REQ-009 ctrl_seq_step_rst  out  1  active-high synchronous clear request to the step counter.
REQ-010 ctrl_seq_step_hold  out  1  step counter must not advance this cycle.
REQ-011 ctrl_seq_halted  out  1  processor halted.
REQ-012 ctrl_seq_illegal  out  1  sticky illegal-opcode flag.

Function
REQ-013 FSM states SHALL be INIT, RUN, HALT; INIT->RUN after one cycle; RUN->HALT on the clock edge where HLT bit of ctrl_seq_word is 1; HALT exits only on reset.
REQ-014 ctrl_seq_word SHALL be combinational from (state, ctrl_seq_step_in, ctrl_seq_ir_opcode, latched flags, ctrl_seq_mem_ready); zero latency.
REQ-015 Fetch: T0 = PC_OUT|MAR_IN; T1 = MEM_RD|IR_IN|PC_INC, for every opcode.
REQ-016 Execute from T2: LDA(1) T2 IR_OUT|MAR_IN, T3 MEM_RD|A_IN; ADD(2) T2 IR_OUT|MAR_IN, T3 MEM_RD|B_IN, T4 ALU_OUT|A_IN|FLAG_IN; SUB(3) as ADD plus ALU_SUB at T4; STA(4) T2 IR_OUT|MAR_IN, T3 A_OUT|MEM_WR; LDI(5) T2 IR_OUT|A_IN; JMP(6) T2 IR_OUT|PC_LOAD; JC(7)/JZ(8) T2 IR_OUT|PC_LOAD only when latched carry/zero is 1, else 0; OUT(14) T2 A_OUT|OUT_IN; NOP(0) none; HLT(15) T2 HLT.
REQ-017 ctrl_seq_step_rst SHALL be 1 during the last micro-step of each opcode (T2 for NOP/LDI/JMP/JC/JZ/OUT/illegal, T3 for LDA/STA, T4 for ADD/SUB) so the counter returns to T0 next edge.
REQ-018 Any step_in >= 5 in RUN SHALL produce ctrl_seq_word = 0 and ctrl_seq_step_rst = 1.
REQ-019 Memory wait: when MEM_RD or MEM_WR is set and ctrl_seq_mem_ready = 0, ctrl_seq_step_hold = 1, MEM_RD/MEM_WR/MAR_IN/PC_OUT/IR_OUT/A_OUT remain set, IR_IN/PC_INC/A_IN/B_IN SHALL be masked to 0 and ctrl_seq_step_rst SHALL be 0.
REQ-020 Flags register (2 bits) SHALL load ctrl_seq_alu_flags on an edge where FLAG_IN is set and not masked.
REQ-021 Opcodes 9..13 at T2 SHALL set ctrl_seq_illegal (sticky until reset) and behave as NOP.
REQ-022 In HALT: ctrl_seq_word = HLT bit only, ctrl_seq_step_hold = 1, ctrl_seq_halted = 1, ctrl_seq_step_rst = 0.

Reset
REQ-023 While ctrl_seq_rst_n = 0: state INIT, flags 00, ctrl_seq_illegal 0, ctrl_seq_halted 0, ctrl_seq_word 0, ctrl_seq_step_hold 0, ctrl_seq_step_rst 1.
REQ-024 In INIT, ctrl_seq_word = 0 and ctrl_seq_step_rst = 1 for exactly one cycle after release.
REQ-025 Reset assertion mid-instruction or mid-wait SHALL abort immediately with no further control bits.

Configuration
REQ-026 Macro CTRL_SEQ_COND_JUMP_EN defined: JC/JZ behave per REQ-016. Undefined: opcodes 7 and 8 SHALL be treated as illegal per REQ-021 and the flags register SHALL be omitted.

Structure
REQ-027 Package ctrl_seq_pkg SHALL hold opcode constants, the 16 control-bit index constants (HLT, MAR_IN, MEM_RD, MEM_WR, IR_IN, IR_OUT, PC_OUT, PC_INC, PC_LOAD, A_IN, A_OUT, B_IN, ALU_OUT, ALU_SUB, OUT_IN, FLAG_IN) and the FSM state encoding.
REQ-028 Sub-module ctrl_seq_decode_rom SHALL implement the combinational (opcode, step, flags) -> word/last-step table; FSM, wait masking and flags register stay in the top.

Verification
REQ-029 Release reset, step_in=0 -> step_rst=1 for one cycle, then word = PC_OUT|MAR_IN.
REQ-030 opcode=2, steps T0..T4, mem_ready=1, alu_flags=2'b10 -> T4 word has ALU_OUT|A_IN|FLAG_IN, step_rst=1; later JC at T2 -> PC_LOAD=1.
REQ-031 T1 with mem_ready=0 for 3 cycles -> step_hold=1, IR_IN=0, PC_INC=0 for 3 cycles; 4th cycle mem_ready=1 -> IR_IN=1, PC_INC=1, step_hold=0.
REQ-032 opcode=10 at T2 -> illegal=1, step_rst=1; illegal stays 1 across following instructions until reset.
REQ-033 opcode=15 at T2 -> next cycle halted=1, step_hold=1, word = HLT only; reset mid-HALT -> all outputs to REQ-023 values.
REQ-034 Build without CTRL_SEQ_COND_JUMP_EN, opcode=7 at T2 -> illegal=1, PC_LOAD=0.
